// File: rtl/calc2_dispatch_sched.sv
// calc2_dispatch_sched: captures two-cycle requests per port, round-robins them onto one ALU, routes tagged completions back
module calc2_dispatch_sched #(
  parameter int DEPTH = 4,
  parameter int DW = 32
) (
  input  logic          ifClk,
  input  logic          ifRst,
  input  logic [3:0]    ifReq1_cmd_in,
  input  logic [3:0]    ifReq2_cmd_in,
  input  logic [3:0]    ifReq3_cmd_in,
  input  logic [3:0]    ifReq4_cmd_in,
  input  logic [DW-1:0] ifReq1_data_in,
  input  logic [DW-1:0] ifReq2_data_in,
  input  logic [DW-1:0] ifReq3_data_in,
  input  logic [DW-1:0] ifReq4_data_in,
  input  logic [1:0]    ifReq1_tag_in,
  input  logic [1:0]    ifReq2_tag_in,
  input  logic [1:0]    ifReq3_tag_in,
  input  logic [1:0]    ifReq4_tag_in,
  output logic [1:0]    ifResp1_out,
  output logic [1:0]    ifResp2_out,
  output logic [1:0]    ifResp3_out,
  output logic [1:0]    ifResp4_out,
  output logic [DW-1:0] ifData1_out,
  output logic [DW-1:0] ifData2_out,
  output logic [DW-1:0] ifData3_out,
  output logic [DW-1:0] ifData4_out,
  output logic [1:0]    ifTag1_out,
  output logic [1:0]    ifTag2_out,
  output logic [1:0]    ifTag3_out,
  output logic [1:0]    ifTag4_out,
  output logic          alu_valid,
  input  logic          alu_ready,
  output logic [3:0]    alu_cmd,
  output logic [DW-1:0] alu_op1,
  output logic [DW-1:0] alu_op2,
  output logic [3:0]    alu_id,
  input  logic          alu_done,
  input  logic [3:0]    alu_done_id,
  input  logic [1:0]    alu_resp,
  input  logic [DW-1:0] alu_result,
  output logic [3:0]    err_tag,
  output logic          err_spurious
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {IDLE, OP2} cap_e;
  typedef struct packed {
    logic [3:0]    cmd;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [1:0]    tag;
  } ent_t;
  logic [3:0]    cmd_in [4];
  logic [DW-1:0] data_in [4];
  logic [1:0]    tag_in [4];
  cap_e          st_q [4], st_d [4];
  ent_t          lat_q [4], lat_d [4];
  ent_t          mem_q [4][DEPTH], mem_d [4][DEPTH];
  logic [AW-1:0] rd_q [4], rd_d [4], wr_q [4], wr_d [4];
  logic [CW-1:0] cnt_q [4], cnt_d [4];
  logic [1:0]    resp_q [4], resp_d [4], tago_q [4], tago_d [4];
  logic [DW-1:0] dat_q [4], dat_d [4];
  logic [15:0]   inf_q, inf_d, clr, set;
  logic          v_q, v_d, espur_q, espur_d, fire, hit, found;
  ent_t          iss_q, iss_d;
  logic [1:0]    port_q, port_d, rr_q, rr_d, ptr, sel;
  logic [3:0]    etag_q, etag_d, push, pop;
  assign cmd_in  = '{ifReq1_cmd_in, ifReq2_cmd_in, ifReq3_cmd_in, ifReq4_cmd_in};
  assign data_in = '{ifReq1_data_in, ifReq2_data_in, ifReq3_data_in, ifReq4_data_in};
  assign tag_in  = '{ifReq1_tag_in, ifReq2_tag_in, ifReq3_tag_in, ifReq4_tag_in};
  // capture, queue push/pop, in-flight tracking, round-robin issue and completion routing
  always_comb begin
    st_d = st_q;
    lat_d = lat_q;
    mem_d = mem_q;
    rd_d = rd_q;
    wr_d = wr_q;
    iss_d = iss_q;
    port_d = port_q;
    rr_d = rr_q;
    etag_d = etag_q;
    push = '0;
    pop = '0;
    set = '0;
    found = 1'b0;
    sel = '0;
    fire = v_q && alu_ready;
    hit = alu_done && inf_q[alu_done_id];
    clr = hit ? (16'd1 << alu_done_id) : 16'd0;
    espur_d = espur_q | (alu_done && !inf_q[alu_done_id]);
    for (int p = 0; p < 4; p++) begin
      resp_d[p] = (hit && alu_done_id[3:2] == 2'(p)) ? alu_resp : '0;
      dat_d[p] = (hit && alu_done_id[3:2] == 2'(p)) ? alu_result : '0;
      tago_d[p] = (hit && alu_done_id[3:2] == 2'(p)) ? alu_done_id[1:0] : '0;
      if (st_q[p] == IDLE) begin
        if (cmd_in[p] != '0) begin
          st_d[p] = OP2;
          lat_d[p].cmd = cmd_in[p];
          lat_d[p].op1 = data_in[p];
          lat_d[p].tag = tag_in[p];
        end
      end else begin
        st_d[p] = IDLE;
        if (inf_q[{2'(p), lat_q[p].tag}] && !clr[{2'(p), lat_q[p].tag}]) etag_d[p] = 1'b1;
        else begin
          push[p] = 1'b1;
          set[{2'(p), lat_q[p].tag}] = 1'b1;
          mem_d[p][wr_q[p]] = lat_q[p];
          mem_d[p][wr_q[p]].op2 = data_in[p];
          wr_d[p] = (wr_q[p] == AW'(DEPTH - 1)) ? '0 : wr_q[p] + AW'(1);
        end
      end
    end
    if (fire) begin
      pop[port_q] = 1'b1;
      rd_d[port_q] = (rd_q[port_q] == AW'(DEPTH - 1)) ? '0 : rd_q[port_q] + AW'(1);
      rr_d = port_q + 2'd1;
    end
    for (int p = 0; p < 4; p++) cnt_d[p] = cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
    ptr = fire ? port_q + 2'd1 : rr_q;
    for (int k = 0; k < 4; k++)
      if (!found && cnt_q[ptr + 2'(k)] > CW'(pop[ptr + 2'(k)])) begin
        found = 1'b1;
        sel = ptr + 2'(k);
      end
    v_d = (!v_q || fire) ? found : v_q;
    if ((!v_q || fire) && found) begin
      iss_d = mem_q[sel][rd_d[sel]];
      port_d = sel;
    end
    inf_d = (inf_q & ~clr) | set;
  end
  // state registers with asynchronous clear
  always_ff @(posedge ifClk or posedge ifRst)
    if (ifRst) begin
      for (int p = 0; p < 4; p++) begin
        st_q[p] <= IDLE;
        lat_q[p] <= '0;
        rd_q[p] <= '0;
        wr_q[p] <= '0;
        cnt_q[p] <= '0;
        resp_q[p] <= '0;
        tago_q[p] <= '0;
        dat_q[p] <= '0;
        for (int d = 0; d < DEPTH; d++) mem_q[p][d] <= '0;
      end
      inf_q <= '0;
      v_q <= 1'b0;
      iss_q <= '0;
      port_q <= '0;
      rr_q <= '0;
      etag_q <= '0;
      espur_q <= 1'b0;
    end else begin
      st_q <= st_d;
      lat_q <= lat_d;
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      resp_q <= resp_d;
      tago_q <= tago_d;
      dat_q <= dat_d;
      inf_q <= inf_d;
      v_q <= v_d;
      iss_q <= iss_d;
      port_q <= port_d;
      rr_q <= rr_d;
      etag_q <= etag_d;
      espur_q <= espur_d;
    end
  assign alu_valid = v_q;
  assign alu_cmd = iss_q.cmd;
  assign alu_op1 = iss_q.op1;
  assign alu_op2 = iss_q.op2;
  assign alu_id = {port_q, iss_q.tag};
  assign err_tag = etag_q;
  assign err_spurious = espur_q;
  assign ifResp1_out = resp_q[0];
  assign ifResp2_out = resp_q[1];
  assign ifResp3_out = resp_q[2];
  assign ifResp4_out = resp_q[3];
  assign ifData1_out = dat_q[0];
  assign ifData2_out = dat_q[1];
  assign ifData3_out = dat_q[2];
  assign ifData4_out = dat_q[3];
  assign ifTag1_out = tago_q[0];
  assign ifTag2_out = tago_q[1];
  assign ifTag3_out = tago_q[2];
  assign ifTag4_out = tago_q[3];
endmodule

// File: tb/tb_calc2_dispatch_sched.sv
// tb_calc2_dispatch_sched: directed checks of capture, round-robin issue, backpressure, tags and completions
module tb_calc2_dispatch_sched;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0][3:0] cmd_i;
  logic [3:0][DW-1:0] data_i;
  logic [3:0][1:0] tag_i;
  logic [3:0][1:0] resp_o, tag_o;
  logic [3:0][DW-1:0] data_o;
  logic alu_valid, alu_ready, alu_done, err_spurious;
  logic [3:0] alu_cmd, alu_id, alu_done_id, err_tag;
  logic [DW-1:0] alu_op1, alu_op2, alu_result;
  logic [1:0] alu_resp;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  calc2_dispatch_sched #(.DEPTH(4), .DW(DW)) dut (
    .ifClk(clk), .ifRst(rst),
    .ifReq1_cmd_in(cmd_i[0]), .ifReq2_cmd_in(cmd_i[1]), .ifReq3_cmd_in(cmd_i[2]), .ifReq4_cmd_in(cmd_i[3]),
    .ifReq1_data_in(data_i[0]), .ifReq2_data_in(data_i[1]), .ifReq3_data_in(data_i[2]), .ifReq4_data_in(data_i[3]),
    .ifReq1_tag_in(tag_i[0]), .ifReq2_tag_in(tag_i[1]), .ifReq3_tag_in(tag_i[2]), .ifReq4_tag_in(tag_i[3]),
    .ifResp1_out(resp_o[0]), .ifResp2_out(resp_o[1]), .ifResp3_out(resp_o[2]), .ifResp4_out(resp_o[3]),
    .ifData1_out(data_o[0]), .ifData2_out(data_o[1]), .ifData3_out(data_o[2]), .ifData4_out(data_o[3]),
    .ifTag1_out(tag_o[0]), .ifTag2_out(tag_o[1]), .ifTag3_out(tag_o[2]), .ifTag4_out(tag_o[3]),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_cmd(alu_cmd), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_id(alu_id), .alu_done(alu_done), .alu_done_id(alu_done_id), .alu_resp(alu_resp),
    .alu_result(alu_result), .err_tag(err_tag), .err_spurious(err_spurious)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    cmd_i = '0;
    data_i = '0;
    tag_i = '0;
    alu_ready = 1'b1;
    alu_done = 1'b0;
    alu_done_id = '0;
    alu_resp = '0;
    alu_result = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", alu_valid, 0);
    chk("rst_id", alu_id, 0);
    chk("rst_resp", resp_o, 0);
    chk("rst_errtag", err_tag, 0);
    chk("rst_errspur", err_spurious, 0);
    tick();
    rst = 1'b0;
    // single request on Req1
    cmd_i[0] = 4'd1; data_i[0] = 5; tag_i[0] = 2'd2;
    tick();
    cmd_i[0] = '0; data_i[0] = 7;
    tick();
    chk("single_not_yet", alu_valid, 0);
    data_i[0] = '0;
    tick();
    chk("single_valid", alu_valid, 1);
    chk("single_id", alu_id, 4'b0010);
    chk("single_cmd", alu_cmd, 1);
    chk("single_op1", alu_op1, 5);
    chk("single_op2", alu_op2, 7);
    tick();
    chk("single_drop", alu_valid, 0);
    tick();
    tick();
    alu_done = 1'b1; alu_done_id = 4'b0010; alu_resp = 2'd1; alu_result = 12;
    tick();
    alu_done = 1'b0;
    chk("single_resp", resp_o, 8'h01);
    chk("single_data", data_o[0], 12);
    chk("single_tag", tag_o, 8'h02);
    chk("single_data_oth", |data_o[3:1], 0);
    tick();
    chk("single_pulse", resp_o, 0);
    chk("single_nospur", err_spurious, 0);
    // fairness: four simultaneous requests from pointer 0
    do_reset();
    for (int p = 0; p < 4; p++) begin cmd_i[p] = 4'd2; data_i[p] = 10 + p; tag_i[p] = 2'd0; end
    tick();
    cmd_i = '0;
    for (int p = 0; p < 4; p++) data_i[p] = 20 + p;
    tick();
    data_i = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("fair1_valid", alu_valid, 1);
      chk("fair1_id", alu_id, {2'(k), 2'b00});
      chk("fair1_op1", alu_op1, 10 + k);
      tick();
    end
    chk("fair1_idle", alu_valid, 0);
    cmd_i[0] = 4'd2; data_i[0] = 1; tag_i[0] = 2'd3;
    tick();
    cmd_i[0] = '0; data_i[0] = 2;
    tick();
    data_i = '0;
    tick();
    chk("fair_mid_id", alu_id, 4'b0011);
    tick();
    chk("fair_mid_idle", alu_valid, 0);
    // second burst, pointer now at port 1
    for (int p = 0; p < 4; p++) begin cmd_i[p] = 4'd2; data_i[p] = 30 + p; tag_i[p] = 2'd1; end
    tick();
    cmd_i = '0;
    tick();
    data_i = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("fair2_valid", alu_valid, 1);
      chk("fair2_id", alu_id, {2'(k + 1), 2'b01});
      chk("fair2_op1", alu_op1, 30 + ((k + 1) % 4));
      tick();
    end
    chk("fair2_idle", alu_valid, 0);
    // backpressure with two queued entries
    alu_ready = 1'b0;
    cmd_i[0] = 4'd3; data_i[0] = 40; tag_i[0] = 2'd2;
    cmd_i[1] = 4'd3; data_i[1] = 41; tag_i[1] = 2'd2;
    tick();
    cmd_i = '0; data_i[0] = 50; data_i[1] = 51;
    tick();
    data_i = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", alu_valid, 1);
      chk("bp_id", alu_id, 4'b0110);
      chk("bp_cmd", alu_cmd, 3);
      chk("bp_op1", alu_op1, 41);
      chk("bp_op2", alu_op2, 51);
      tick();
    end
    alu_ready = 1'b1;
    tick();
    chk("bp_b2b_valid", alu_valid, 1);
    chk("bp_b2b_id", alu_id, 4'b0010);
    chk("bp_b2b_op1", alu_op1, 40);
    chk("bp_b2b_op2", alu_op2, 50);
    tick();
    chk("bp_idle", alu_valid, 0);
    // tag reuse on Req3
    do_reset();
    cmd_i[2] = 4'd4; data_i[2] = 100; tag_i[2] = 2'd1;
    tick();
    cmd_i[2] = '0; data_i[2] = 101;
    tick();
    cmd_i[2] = 4'd4; data_i[2] = 110; tag_i[2] = 2'd1;
    tick();
    chk("reuse_first_id", alu_id, 4'b1001);
    chk("reuse_first_op1", alu_op1, 100);
    cmd_i[2] = '0; data_i[2] = 111;
    tick();
    chk("reuse_errtag", err_tag, 4'b0100);
    data_i = '0;
    tick();
    chk("reuse_noissue1", alu_valid, 0);
    tick();
    chk("reuse_noissue2", alu_valid, 0);
    alu_done = 1'b1; alu_done_id = 4'b1001; alu_resp = 2'd2; alu_result = 55;
    tick();
    alu_done = 1'b0;
    chk("reuse_resp", resp_o, 8'h20);
    chk("reuse_data", data_o[2], 55);
    chk("reuse_tag", tag_o, 8'h10);
    cmd_i[2] = 4'd4; data_i[2] = 200; tag_i[2] = 2'd1;
    tick();
    cmd_i[2] = '0; data_i[2] = 201;
    tick();
    data_i = '0;
    tick();
    chk("reuse_again_valid", alu_valid, 1);
    chk("reuse_again_id", alu_id, 4'b1001);
    chk("reuse_again_op1", alu_op1, 200);
    tick();
    chk("reuse_sticky", err_tag, 4'b0100);
    // completion and push of the same id in one cycle
    cmd_i[2] = 4'd5; data_i[2] = 300; tag_i[2] = 2'd1;
    tick();
    cmd_i[2] = '0; data_i[2] = 301;
    alu_done = 1'b1; alu_done_id = 4'b1001; alu_resp = 2'd1; alu_result = 77;
    tick();
    alu_done = 1'b0; data_i = '0;
    chk("same_resp", resp_o, 8'h10);
    chk("same_data", data_o[2], 77);
    chk("same_errtag", err_tag, 4'b0100);
    tick();
    chk("same_issue_id", alu_id, 4'b1001);
    chk("same_issue_op1", alu_op1, 300);
    chk("same_issue_op2", alu_op2, 301);
    tick();
    alu_done = 1'b1; alu_done_id = 4'b1001; alu_resp = 2'd3; alu_result = 88;
    tick();
    alu_done = 1'b0;
    chk("same_bitset_resp", resp_o, 8'h30);
    chk("same_bitset_data", data_o[2], 88);
    chk("same_nospur", err_spurious, 0);
    // spurious completion
    alu_done = 1'b1; alu_done_id = 4'hF; alu_resp = 2'd3; alu_result = 99;
    tick();
    alu_done = 1'b0;
    chk("spur_resp", resp_o, 0);
    chk("spur_data", |data_o, 0);
    chk("spur_flag", err_spurious, 1);
    tick();
    chk("spur_sticky", err_spurious, 1);
    // reset in the middle of a capture with two entries queued
    alu_ready = 1'b0;
    cmd_i[0] = 4'd6; data_i[0] = 60; tag_i[0] = 2'd0;
    cmd_i[1] = 4'd6; data_i[1] = 61; tag_i[1] = 2'd0;
    tick();
    cmd_i = '0; data_i[0] = 70; data_i[1] = 71;
    tick();
    data_i = '0;
    tick();
    chk("mid_pre_valid", alu_valid, 1);
    cmd_i[3] = 4'd7; data_i[3] = 80; tag_i[3] = 2'd2;
    tick();
    cmd_i[3] = '0; data_i[3] = 81;
    rst = 1'b1;
    #1;
    chk("mid_valid", alu_valid, 0);
    chk("mid_id", alu_id, 0);
    chk("mid_cmd", alu_cmd, 0);
    chk("mid_op1", alu_op1, 0);
    chk("mid_op2", alu_op2, 0);
    chk("mid_errtag", err_tag, 0);
    chk("mid_errspur", err_spurious, 0);
    chk("mid_resp", resp_o, 0);
    tick();
    rst = 1'b0;
    data_i = '0;
    alu_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_stale", alu_valid, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
